// File: rtl/stream_demux4_if.sv
// Handshake bundle for stream_demux4: one input stream, four output lanes, lock status.
// Optional statistics ports exist only when STREAM_DEMUX4_STATS_EN is defined.
interface stream_demux4_if #(
  parameter int WIDTH = 16
);
  logic               io_in_valid;
  logic               io_in_ready;
  logic [WIDTH-1:0]   io_in_data;
  logic               io_in_last;
  logic [1:0]         io_in_sel;
  logic [3:0]         io_out_valid;
  logic [3:0]         io_out_ready;
  logic [4*WIDTH-1:0] io_out_data;
  logic [3:0]         io_out_last;
  logic               io_busy;
  logic [1:0]         io_lock_sel;
`ifdef STREAM_DEMUX4_STATS_EN
  logic [1:0]         io_stat_sel;
  logic [15:0]        io_stat_count;

  modport slave (
    input  io_in_valid, io_in_data, io_in_last, io_in_sel, io_out_ready, io_stat_sel,
    output io_in_ready, io_out_valid, io_out_data, io_out_last, io_busy, io_lock_sel,
           io_stat_count
  );
  modport master (
    output io_in_valid, io_in_data, io_in_last, io_in_sel, io_out_ready, io_stat_sel,
    input  io_in_ready, io_out_valid, io_out_data, io_out_last, io_busy, io_lock_sel,
           io_stat_count
  );
`else
  modport slave (
    input  io_in_valid, io_in_data, io_in_last, io_in_sel, io_out_ready,
    output io_in_ready, io_out_valid, io_out_data, io_out_last, io_busy, io_lock_sel
  );
  modport master (
    output io_in_valid, io_in_data, io_in_last, io_in_sel, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_data, io_out_last, io_busy, io_lock_sel
  );
`endif
endinterface

// File: rtl/stream_demux4.sv
// 1-to-4 packet-routing stream demux with a one-entry registered slot per output lane.
// Define STREAM_DEMUX4_STATS_EN to add per-destination saturating packet counters.
module stream_demux4 #(
  parameter int WIDTH = 16
) (
  input  logic           clock,
  input  logic           reset,
  stream_demux4_if.slave bus
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [1:0]            lock_sel_q, lock_sel_d;
  logic [3:0]            slot_valid_q, slot_valid_d;
  logic [3:0]            slot_last_q, slot_last_d;
  logic [3:0][WIDTH-1:0] slot_data_q, slot_data_d;

  logic [1:0] route;
  logic       in_ready;
  logic       accept;
  logic [3:0] drain;

  // The lock only redirects routing once a packet head has been accepted.
  assign route    = (state_q == LOCKED) ? lock_sel_q : bus.io_in_sel;
  assign in_ready = !slot_valid_q[route] || bus.io_out_ready[route];
  assign accept   = bus.io_in_valid && in_ready;
  assign drain    = slot_valid_q & bus.io_out_ready;

  always_comb begin
    state_d      = state_q;
    lock_sel_d   = lock_sel_q;
    slot_valid_d = slot_valid_q & ~drain;
    slot_last_d  = slot_last_q;
    slot_data_d  = slot_data_q;
    if (accept) begin
      // A fill overrides a same-cycle drain of the same slot.
      slot_valid_d[route] = 1'b1;
      slot_last_d[route]  = bus.io_in_last;
      slot_data_d[route]  = bus.io_in_data;
      if (state_q == IDLE) begin
        if (!bus.io_in_last) begin
          state_d    = LOCKED;
          lock_sel_d = bus.io_in_sel;
        end
      end else if (bus.io_in_last) begin
        state_d    = IDLE;
        lock_sel_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lock_sel_q   <= 2'd0;
      slot_valid_q <= '0;
      slot_last_q  <= '0;
      slot_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      lock_sel_q   <= lock_sel_d;
      slot_valid_q <= slot_valid_d;
      slot_last_q  <= slot_last_d;
      slot_data_q  <= slot_data_d;
    end
  end

  assign bus.io_in_ready  = in_ready;
  assign bus.io_out_valid = slot_valid_q;
  assign bus.io_out_last  = slot_last_q;
  assign bus.io_out_data  = slot_data_q;
  assign bus.io_busy      = (state_q == LOCKED);
  assign bus.io_lock_sel  = lock_sel_q;

`ifdef STREAM_DEMUX4_STATS_EN
  logic [3:0][15:0] cnt_q, cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (accept && bus.io_in_last) cnt_d[route] = sat_inc(cnt_q[route]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.io_stat_count = cnt_q[bus.io_stat_sel];
`endif
endmodule

// File: tb/tb_stream_demux4.sv
// Directed table-driven bench for stream_demux4 plus hand-written reset sequences.
module tb_stream_demux4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  stream_demux4_if #(.WIDTH(16)) bus ();
  stream_demux4 #(.WIDTH(16)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [15:0] data;
    logic        last;
    logic [3:0]  ord;
    logic        e_rdy;
    logic [3:0]  e_oval;
    logic [3:0]  e_olast;
    logic        e_busy;
    logic [1:0]  e_lsel;
    int          lane;
    logic [15:0] e_data;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane_data(input int k);
    logic [63:0] d;
    d = bus.io_out_data;
    return d[k*16 +: 16];
  endfunction

  task automatic drive(input logic v, input logic [1:0] sel, input logic [15:0] data,
                       input logic last, input logic [3:0] ord);
    bus.io_in_valid  = v;
    bus.io_in_sel    = sel;
    bus.io_in_data   = data;
    bus.io_in_last   = last;
    bus.io_out_ready = ord;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'd2, 16'hA5A5, 1'b1, 4'hF, 1'b1, 4'b0100, 4'b0100, 1'b0, 2'd0, 2, 16'hA5A5};
    vecs[1]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'b0000, 4'b0100, 1'b0, 2'd0, 2, 16'hA5A5};
    vecs[2]  = '{1'b1, 2'd1, 16'h0011, 1'b0, 4'hF, 1'b1, 4'b0010, 4'b0100, 1'b1, 2'd1, 1, 16'h0011};
    vecs[3]  = '{1'b1, 2'd3, 16'h0022, 1'b0, 4'hF, 1'b1, 4'b0010, 4'b0100, 1'b1, 2'd1, 1, 16'h0022};
    vecs[4]  = '{1'b1, 2'd3, 16'h0033, 1'b1, 4'hF, 1'b1, 4'b0010, 4'b0110, 1'b0, 2'd0, 1, 16'h0033};
    vecs[5]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'b0000, 4'b0110, 1'b0, 2'd0, 1, 16'h0033};
    vecs[6]  = '{1'b1, 2'd0, 16'h0B01, 1'b1, 4'hE, 1'b1, 4'b0001, 4'b0111, 1'b0, 2'd0, 0, 16'h0B01};
    vecs[7]  = '{1'b1, 2'd0, 16'h0B02, 1'b1, 4'hE, 1'b0, 4'b0001, 4'b0111, 1'b0, 2'd0, 0, 16'h0B01};
    vecs[8]  = '{1'b1, 2'd0, 16'h0B02, 1'b1, 4'hF, 1'b1, 4'b0001, 4'b0111, 1'b0, 2'd0, 0, 16'h0B02};
    vecs[9]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 4'hF, 1'b1, 4'b0000, 4'b0111, 1'b0, 2'd0, 0, 16'h0B02};
    vecs[10] = '{1'b1, 2'd3, 16'h0C03, 1'b1, 4'h7, 1'b1, 4'b1000, 4'b1111, 1'b0, 2'd0, 3, 16'h0C03};
    vecs[11] = '{1'b1, 2'd0, 16'h0D01, 1'b0, 4'h7, 1'b1, 4'b1001, 4'b1110, 1'b1, 2'd0, 0, 16'h0D01};
    vecs[12] = '{1'b1, 2'd3, 16'h0D02, 1'b0, 4'h7, 1'b1, 4'b1001, 4'b1110, 1'b1, 2'd0, 3, 16'h0C03};
    vecs[13] = '{1'b1, 2'd3, 16'h0D03, 1'b1, 4'h7, 1'b1, 4'b1001, 4'b1111, 1'b0, 2'd0, 0, 16'h0D03};
    vecs[14] = '{1'b1, 2'd3, 16'h0E00, 1'b1, 4'h7, 1'b0, 4'b1000, 4'b1111, 1'b0, 2'd0, 3, 16'h0C03};
    vecs[15] = '{1'b0, 2'd3, 16'h0000, 1'b0, 4'hF, 1'b1, 4'b0000, 4'b1111, 1'b0, 2'd0, 3, 16'h0C03};

`ifdef STREAM_DEMUX4_STATS_EN
    bus.io_stat_sel = 2'd0;
`endif
    // Reset held low with random activity on the inputs.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      drive(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom), 4'($urandom));
      #1;
      check("rst_oval", 32'(bus.io_out_valid), 32'h0);
      check("rst_busy", 32'(bus.io_busy), 32'h0);
      check("rst_rdy", 32'(bus.io_in_ready), 32'h1);
      check("rst_lsel", 32'(bus.io_lock_sel), 32'h0);
    end
    @(negedge clock);
    drive(1'b0, 2'd0, 16'h0, 1'b0, 4'hF);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].last, vecs[i].ord);
      #1;
      check($sformatf("v%0d_rdy", i), 32'(bus.io_in_ready), 32'(vecs[i].e_rdy));
      @(posedge clock);
      #1;
      check($sformatf("v%0d_oval", i), 32'(bus.io_out_valid), 32'(vecs[i].e_oval));
      check($sformatf("v%0d_olast", i), 32'(bus.io_out_last), 32'(vecs[i].e_olast));
      check($sformatf("v%0d_busy", i), 32'(bus.io_busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d_lsel", i), 32'(bus.io_lock_sel), 32'(vecs[i].e_lsel));
      check($sformatf("v%0d_lane%0d", i, vecs[i].lane), 32'(lane_data(vecs[i].lane)),
            32'(vecs[i].e_data));
    end

`ifdef STREAM_DEMUX4_STATS_EN
    begin
      logic [15:0] exp_cnt[4] = '{16'd3, 16'd1, 16'd1, 16'd1};
      for (int k = 0; k < 4; k++) begin
        bus.io_stat_sel = 2'(k);
        #1;
        check($sformatf("stat%0d", k), 32'(bus.io_stat_count), 32'(exp_cnt[k]));
      end
    end
`endif

    // Asynchronous reset in the middle of a 4-beat packet to lane 1.
    @(negedge clock);
    drive(1'b1, 2'd1, 16'h1001, 1'b0, 4'hF);
    @(posedge clock);
    @(negedge clock);
    drive(1'b1, 2'd0, 16'h1002, 1'b0, 4'hF);
    @(posedge clock);
    #1;
    check("mid_busy", 32'(bus.io_busy), 32'h1);
    check("mid_lane1", 32'(lane_data(1)), 32'h1002);
    @(negedge clock);
    drive(1'b0, 2'd0, 16'h0, 1'b0, 4'h0);
    #1 reset = 1'b0;
    #1;
    check("arst_busy", 32'(bus.io_busy), 32'h0);
    check("arst_oval", 32'(bus.io_out_valid), 32'h0);
    check("arst_lsel", 32'(bus.io_lock_sel), 32'h0);
`ifdef STREAM_DEMUX4_STATS_EN
    bus.io_stat_sel = 2'd1;
    #1;
    check("arst_stat1", 32'(bus.io_stat_count), 32'h0);
`endif
    #1 reset = 1'b1;
    @(negedge clock);
    drive(1'b1, 2'd2, 16'h2222, 1'b1, 4'h0);
    #1;
    check("post_rdy", 32'(bus.io_in_ready), 32'h1);
    @(posedge clock);
    #1;
    check("post_oval", 32'(bus.io_out_valid), 32'h4);
    check("post_lane2", 32'(lane_data(2)), 32'h2222);
    check("post_busy", 32'(bus.io_busy), 32'h0);
`ifdef STREAM_DEMUX4_STATS_EN
    bus.io_stat_sel = 2'd2;
    #1;
    check("post_stat2", 32'(bus.io_stat_count), 32'h1);
`endif
    @(negedge clock);
    drive(1'b0, 2'd0, 16'h0, 1'b0, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_demux4.md
Name: stream_demux4

Overview:
- 1-to-4 streaming demultiplexer: the inverse of the 4:1 select-mux tree.
- Routes WIDTH-bit words from one valid/ready input stream to one of four valid/ready output streams.
- Uses packet-level routing: the select is sampled on the first beat of a packet and held until its last beat.
- Each output has a one-entry registered slot, so the outputs are fully decoupled from one another.

Parameters:
- WIDTH, 16, data width of the input and of each output lane.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_in_valid  input  1  an input word is presented.
- io_in_ready  output  1  the block can accept the presented word this cycle.
- io_in_data  input  WIDTH  input word.
- io_in_last  input  1  marks the final beat of a packet.
- io_in_sel  input  2  destination output; only sampled in IDLE.
- io_out_valid  output  4  bit k: output k slot holds a word.
- io_out_ready  input  4  bit k: consumer k accepts its word this cycle.
- io_out_data  output  4*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- io_out_last  output  4  bit k: last flag of the word in slot k.
- io_busy  output  1  1 while in LOCKED (a packet is mid-transfer).
- io_lock_sel  output  2  the latched destination; 0 when IDLE.

Behaviour:
- Reset is asserted by reset=0, asynchronously. It forces:
  - state = IDLE, lock_sel = 0
  - all slot valid, data and last registers = 0
  - therefore io_out_valid = 0, io_busy = 0, io_lock_sel = 0.
- FSM states IDLE and LOCKED. Routing target:
  - route = io_in_sel in IDLE
  - route = lock_sel in LOCKED; io_in_sel is ignored in LOCKED.
- io_in_ready = !slot_valid[route] | io_out_ready[route].
  - This is combinational from io_out_ready; there is no path from io_in_valid to io_in_ready.
- Accept = io_in_valid & io_in_ready. On accept:
  - slot[route] <= {io_in_data, io_in_last}, and slot_valid[route] <= 1.
- FSM transitions on accept:
  - IDLE with last=0 → LOCKED, lock_sel <= io_in_sel.
  - IDLE with last=1 → stays IDLE (single-beat packet).
  - LOCKED with last=1 → IDLE, lock_sel <= 0.
  - LOCKED with last=0 → stays LOCKED.
- No accept means no state change.
- Drain on output k = out_valid[k] & out_ready[k]:
  - slot_valid[k] <= 0, unless a fill into slot k happens in the same cycle. A simultaneous fill and drain keeps valid=1 and loads the new word.
- Latency: a word accepted at edge n is presented on io_out from cycle n+1 onward. Throughput is 1 word/cycle per lane when the consumer holds ready high.
- Non-selected slots are untouched. They keep presenting their data and drain independently, including while another lane is LOCKED.
- Data and last of an occupied slot are stable until that slot drains.
- Valid-only backpressure: if io_in_valid=1 and the target slot is full and not draining, then io_in_ready=0 and nothing changes. The upstream must hold its word.
- Reset mid-packet discards the slot contents and the lock. The next accepted beat is treated as a packet head.

Optional Feature:
- Macro: STREAM_DEMUX4_STATS_EN.
- When defined:
  - Adds input io_stat_sel[1:0] and output io_stat_count[15:0].
  - Adds four 16-bit counters, each counting packets completed (accepted beats with last=1) per destination. Counters saturate at 16'hFFFF and are cleared by reset.
  - io_stat_count = counter[io_stat_sel], combinational.
- When undefined: these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset: hold reset=0 with random inputs → io_out_valid=4'b0000, io_busy=0, io_in_ready=1. Release → first accepted word appears one cycle later.
- Single beats: sel=2, data=16'hA5A5, last=1, out_ready=4'b1111 → cycle n+1: io_out_valid=4'b0100, lane 2 = 16'hA5A5, io_out_last[2]=1, io_busy=0.
- Lock: 3-beat packet sel=1 (0x0011, 0x0022, 0x0033 with last on the third); change io_in_sel to 3 on beats 2–3 → all three words exit lane 1 in order. io_busy=1 after beat 1 and 0 after beat 3.
- Backpressure: out_ready[0]=0, send two words to sel=0 → first word held with io_in_ready=0. Raise out_ready[0] → drain and refill in the same cycle with no bubble; second word appears next cycle.
- Independence: lane 3 full and stalled while a packet streams to lane 0 with ready=1 → lane 0 runs at 1 word/cycle and lane 3 data stays stable.
- Async reset mid-packet: after beat 2 of a 4-beat packet to lane 1, pulse reset=0 between edges → immediate io_busy=0 and io_out_valid=0. The next word with sel=2 routes to lane 2. With STREAM_DEMUX4_STATS_EN, count[1]=0.
